// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR read-return path.
//   DDR_WORD_W       - MCB user-port data width
//   DDR_BURST_WORDS  - 128-bit words per read burst (cmd_bl = 23)
//   CHN_W            - channel index width
//   CNT_W            - burst word counter width (covers bursts up to 64)
//   rd_state_t       - one-hot read-return FSM states
package ddr_pkg;
  localparam int DDR_WORD_W      = 128;
  localparam int DDR_BURST_WORDS = 24;
  localparam int CHN_W           = 10;
  localparam int CNT_W           = 6;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_LOAD  = 4'b0010,
    ST_TAG   = 4'b0100,
    ST_BURST = 4'b1000
  } rd_state_t;
endpackage

// File: rtl/ddr_rdtag_fifo.sv
// Issued-read tag FIFO: records the channel of each accepted read command
// until its burst returns.
//   clk, rst_n  - clock, async active-low reset
//   push, din   - write a tag
//   pop, dout   - read a tag; dout is registered (valid the cycle after pop)
//   full, empty - occupancy status
//   drop        - push rejected because the FIFO was full and not popping
module ddr_rdtag_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO proceeds.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ddr_read_ctrl.sv
// Read-return controller: drains the MCB read-data FIFO one burst at a time,
// tags each burst with the channel recorded at command issue, and emits a
// framed word stream (sof/eof/chn) to the packet builder.
//   rd_cmd_issue/rd_cmd_chn      - read command accepted by memc, with channel
//   memc_rd_empty/data/count/en  - MCB read FIFO (FWFT); count is debug only
//   pkt_rd_bp                    - downstream stop; pkt_rd_* framed output
//   tag_full                     - tag FIFO full status
//   err_tag_ovf/err_tag_unf      - sticky error flags, cleared by reset only
module ddr_read_ctrl #(
  parameter int BURST_WORDS = ddr_pkg::DDR_BURST_WORDS,
  parameter int TAG_DEPTH   = 16,
  parameter int CHN_W       = ddr_pkg::CHN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_cmd_issue,
  input  logic [CHN_W-1:0] rd_cmd_chn,
  input  logic             memc_rd_empty,
  input  logic [127:0]     memc_rd_data,
  input  logic [6:0]       memc_rd_count,
  output logic             memc_rd_en,
  input  logic             pkt_rd_bp,
  output logic             pkt_rd_val,
  output logic             pkt_rd_sof,
  output logic             pkt_rd_eof,
  output logic [127:0]     pkt_rd_data,
  output logic [CHN_W-1:0] pkt_rd_chn,
  output logic             tag_full,
  output logic             err_tag_ovf,
  output logic             err_tag_unf
);
  import ddr_pkg::*;

  rd_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             tag_pop, tag_empty, tag_drop;
  logic [CHN_W-1:0] tag_dout;

  // Occupancy is informational only; kept on the port for debug visibility.
  logic unused_count;
  assign unused_count = ^memc_rd_count;

  ddr_rdtag_fifo #(.W(CHN_W), .DEPTH(TAG_DEPTH)) u_tag (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_cmd_issue),
    .din   (rd_cmd_chn),
    .pop   (tag_pop),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty),
    .drop  (tag_drop)
  );

  assign tag_pop    = (state == ST_LOAD);
  assign last       = (cnt == CNT_W'(BURST_WORDS - 1));
  // Backpressure only blocks new pops; the word already registered is still shown.
  assign memc_rd_en = (state == ST_BURST) & ~memc_rd_empty & ~pkt_rd_bp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pkt_rd_val  <= 1'b0;
      pkt_rd_sof  <= 1'b0;
      pkt_rd_eof  <= 1'b0;
      pkt_rd_data <= '0;
      pkt_rd_chn  <= '0;
      err_tag_ovf <= 1'b0;
      err_tag_unf <= 1'b0;
    end else begin
      pkt_rd_val <= memc_rd_en;
      pkt_rd_sof <= memc_rd_en & (cnt == '0);
      pkt_rd_eof <= memc_rd_en & last;
      if (memc_rd_en) pkt_rd_data <= memc_rd_data;
      if (tag_drop)   err_tag_ovf <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (!tag_empty)          state <= ST_LOAD;
          else if (!memc_rd_empty) err_tag_unf <= 1'b1;  // data with no owner
        end
        ST_LOAD: state <= ST_TAG;  // tag dout lands next cycle
        ST_TAG: begin
          pkt_rd_chn <= tag_dout;
          cnt        <= '0;
          state      <= ST_BURST;
        end
        ST_BURST: begin
          if (memc_rd_en) begin
            if (last) begin
              cnt   <= '0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
